// File: rtl/lsu_types.sv
// Load/store unit types: FSM states, access sizes and the funct3 decoder.
package lsu_types;
  import rv32i_types::*;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_t;

  typedef struct packed {
    logic      legal;
    lsu_size_t size;
    logic      uns;
  } lsu_decode_t;

  // Map funct3 to size/signedness; 64-bit forms are only legal when wide=1.
  function automatic lsu_decode_t lsu_decode(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic       wide);
    lsu_decode_t d;
    d.legal = 1'b0;
    d.size  = SZ_B;
    d.uns   = 1'b0;
    if (we) begin
      case (funct3)
        SB:      begin d.legal = 1'b1; d.size = SZ_B; end
        SH:      begin d.legal = 1'b1; d.size = SZ_H; end
        SW:      begin d.legal = 1'b1; d.size = SZ_W; end
        SD:      begin d.legal = wide; d.size = SZ_D; end
        default: d.legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        LB:      begin d.legal = 1'b1; d.size = SZ_B; end
        LH:      begin d.legal = 1'b1; d.size = SZ_H; end
        LW:      begin d.legal = 1'b1; d.size = SZ_W; end
        LD:      begin d.legal = wide; d.size = SZ_D; end
        LBU:     begin d.legal = 1'b1; d.size = SZ_B; d.uns = 1'b1; end
        LHU:     begin d.legal = 1'b1; d.size = SZ_H; d.uns = 1'b1; end
        LWU:     begin d.legal = wide; d.size = SZ_W; d.uns = 1'b1; end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// RV32I/RV64I load and store funct3 encodings shared across the core.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010,
    SD = 3'b011
  } store_funct3_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replicated store data,
// load right-shift and sign/zero extension.
module lsu_align
  import lsu_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  lsu_size_t                 size,
  input  logic                      uns,
  input  logic [XLEN-1:0]           store_data,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic [XLEN/8-1:0]         byte_enable,
  output logic [XLEN-1:0]           lane_wdata,
  output logic [XLEN-1:0]           load_data
);

  localparam int NB = XLEN / 8;

  logic [NB-1:0]   base_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign;

  // Store side: size mask moved to the lane offset, data copied into every lane.
  always_comb begin
    base_mask  = '0;
    lane_wdata = '0;
    case (size)
      SZ_B:    base_mask = NB'(1);
      SZ_H:    base_mask = NB'(3);
      SZ_W:    base_mask = NB'(15);
      default: base_mask = '1;
    endcase
    byte_enable = base_mask << off;
    for (int i = 0; i < NB; i++) begin
      case (size)
        SZ_B:    lane_wdata[i*8 +: 8] = store_data[7:0];
        SZ_H:    lane_wdata[i*8 +: 8] = store_data[(i%2)*8 +: 8];
        SZ_W:    lane_wdata[i*8 +: 8] = store_data[(i%4)*8 +: 8];
        default: lane_wdata[i*8 +: 8] = store_data[i*8 +: 8];
      endcase
    end
  end

  // Load side: bring the addressed lane to bit 0, then mask and extend.
  always_comb begin
    shifted   = mem_rdata >> {off, 3'b000};
    keep_mask = '1;
    sign      = 1'b0;
    case (size)
      SZ_B: begin keep_mask = XLEN'(8'hFF);          sign = shifted[7];  end
      SZ_H: begin keep_mask = XLEN'(16'hFFFF);       sign = shifted[15]; end
      SZ_W: begin keep_mask = XLEN'(32'hFFFF_FFFF);  sign = shifted[31]; end
      default: begin keep_mask = '1;                 sign = 1'b0;        end
    endcase
    load_data = shifted & keep_mask;
    if (!uns && sign) begin
      load_data = load_data | ~keep_mask;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, drives a simple memory
// strobe interface and returns a single-cycle response.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses fault
// without touching memory; when undefined the address is rounded down to the
// natural alignment of the access and the access proceeds.
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while idle. Memory strobes
// stay asserted with stable address/data until a cycle with mem_resp high.
// resp_valid is a one-cycle pulse with no backpressure.
module load_store_unit
  import lsu_types::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_byte_enable,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_resp,
  output lsu_state_t          dbg_state
);

  localparam int   NB   = XLEN / 8;
  localparam int   OFFW = $clog2(NB);
  localparam logic WIDE = (XLEN == 64);

  lsu_state_t state, state_next;

  logic              we_q;
  lsu_size_t         size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  lsu_decode_t       dec;
  logic [OFFW-1:0]   low_mask;
  logic              fault;
  logic [ADDR_W-1:0] req_addr_eff;

  logic [NB-1:0]     align_be;
  logic [XLEN-1:0]   align_wdata;
  logic [XLEN-1:0]   align_rdata;

  // Decode the incoming request and decide whether it faults before memory.
  always_comb begin
    dec = lsu_decode(req_we, req_funct3, WIDE);
    case (dec.size)
      SZ_B:    low_mask = '0;
      SZ_H:    low_mask = OFFW'(1);
      SZ_W:    low_mask = OFFW'(3);
      default: low_mask = OFFW'(7);
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    fault        = !dec.legal || ((req_addr[OFFW-1:0] & low_mask) != '0);
    req_addr_eff = req_addr;
`else
    fault        = !dec.legal;
    req_addr_eff = req_addr & ~ADDR_W'(low_mask);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture on acceptance and load data capture on memory completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= dec.size;
            uns_q   <= dec.uns;
            addr_q  <= req_addr_eff;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= fault;
          end
        end
        ST_ACCESS: begin
          if (mem_resp && !we_q) begin
            rdata_q <= align_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; memory outputs are only non-zero in ACCESS.
  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_err        = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = fault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_read    = !we_q;
        mem_write   = we_q;
        mem_address = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        if (we_q) begin
          mem_wdata       = align_wdata;
          mem_byte_enable = align_be;
        end
        if (mem_resp) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off        (addr_q[OFFW-1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .store_data (wdata_q),
    .mem_rdata  (mem_rdata),
    .byte_enable(align_be),
    .lane_wdata (align_wdata),
    .load_data  (align_rdata)
  );

endmodule
